// File: rtl/cacheline_burst_tx.sv
// ============================================================================
// Module   : cacheline_burst_tx
// Purpose  : Latches one cache line and writes it to memory as 64-bit beats.
//            Optional per-beat response timeout: CACHELINE_TX_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module cacheline_burst_tx #(
  parameter int width   = 256,
  parameter int BEATS   = width / 64,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [31:0]      addr_in,
  input  logic [width-1:0] line_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             mem_write,
  output logic [31:0]      mem_address,
  output logic [63:0]      mem_wdata,
  input  logic             mem_resp
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [31:5]      addr_q, addr_d;
  logic [width-1:0] line_q, line_d;

  // Line offset bits never reach memory; the burst always starts line-aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_in[4:0];

`ifdef CACHELINE_TX_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    line_d  = line_q;
`ifdef CACHELINE_TX_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = addr_in[31:5];
          line_d  = line_in;
          beat_d  = '0;
          state_d = S_SEND;
`ifdef CACHELINE_TX_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      S_SEND: begin
        if (mem_resp) begin
`ifdef CACHELINE_TX_TIMEOUT_EN
          tmo_d = '0;
`endif
          if (beat_q == LAST_BEAT) begin
            state_d = S_DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
`ifdef CACHELINE_TX_TIMEOUT_EN
        // Abort on the TIMEOUT-th consecutive stalled cycle of one beat.
        else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
    end
  end

`ifdef CACHELINE_TX_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign mem_write   = (state_q == S_SEND);
  assign mem_address = {addr_q, 5'b0};
  assign mem_wdata   = line_q[64*int'(beat_q) +: 64];

endmodule

`default_nettype wire

// File: tb/tb_cacheline_burst_tx.sv
// ============================================================================
// Module   : tb_cacheline_burst_tx
// Purpose  : Scoreboard bench for cacheline_burst_tx (random + directed bursts).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cacheline_burst_tx;

  localparam int W   = 256;
  localparam int NB  = W / 64;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic [31:0]   addr_in = '0;
  logic [W-1:0]  line_in = '0;
  logic          mem_resp = 1'b0;
  logic          busy, done, err, mem_write;
  logic [31:0]   mem_address;
  logic [63:0]   mem_wdata;

  cacheline_burst_tx #(.width(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr_in(addr_in), .line_in(line_in),
    .busy(busy), .done(done), .err(err), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [63:0] d;
  } beat_t;

  beat_t exp_q[$];
  int    done_q[$];
  bit    exp_send = 1'b0;
  bit    exp_err  = 1'b0;
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic rand_line(output logic [W-1:0] v);
    for (int i = 0; i < W / 32; i++) v[32*i +: 32] = $urandom;
  endtask

  task automatic junk();
    logic [W-1:0] v;
    req = ($urandom_range(0, 3) == 0);
    addr_in = $urandom;
    rand_line(v);
    line_in = v;
  endtask

  // Monitor: every SEND cycle must present the scoreboard's head beat.
  always @(negedge clk) begin
    if (rst_n) begin
      bit de;
      de = (done_q.size() > 0) && (done_q[0] == cyc);
      check("mem_write", mem_write, exp_send);
      check("done", done, de);
      if (de) void'(done_q.pop_front());
      check("busy", busy, exp_send || de);
      check("err", err, exp_err);
      if (mem_write) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL beat at cycle %0d: got unexpected beat %0h, expected none", cyc, mem_wdata);
        end else begin
          check("mem_address", mem_address, exp_q[0].a);
          check("mem_wdata", mem_wdata, exp_q[0].d);
          if (mem_resp) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge that leaves DONE.
  task automatic burst(input logic [31:0] a, input logic [W-1:0] l, input int stall, input bit noise);
    int st[NB];
    int total = 0;
    req = 1'b1;
    addr_in = a;
    line_in = l;
    mem_resp = noise ? 1'($urandom % 2) : 1'b0;
    for (int k = 0; k < NB; k++) begin
      st[k] = (stall < 0) ? $urandom_range(0, 3) : stall;
      total += st[k];
      exp_q.push_back('{a: (a / 32) * 32, d: l[64*k +: 64]});
    end
    done_q.push_back(cyc + 1 + NB + total);
    @(posedge clk); #1;
    exp_send = 1'b1;
    req = 1'b0;
    for (int k = 0; k < NB; k++) begin
      for (int s = 0; s < st[k]; s++) begin
        mem_resp = 1'b0;
        if (noise) junk();
        @(posedge clk); #1;
      end
      mem_resp = 1'b1;
      if (noise) junk();
      @(posedge clk); #1;
    end
    exp_send = 1'b0;
    mem_resp = noise ? 1'($urandom % 2) : 1'b0;
    if (noise) junk();
    @(posedge clk); #1;
    req = 1'b0;
    mem_resp = 1'b0;
  endtask

  initial begin
    logic [W-1:0] v;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {busy, done, err, mem_write, mem_address, mem_wdata}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < NB; k++) v[64*k +: 64] = {16{4'(k + 1)}};
    burst(32'h0000_1234, v, 0, 1'b0);
    rand_line(v);
    burst(32'h0000_1234, v, 3, 1'b0);
    for (int n = 0; n < 20; n++) begin
      rand_line(v);
      burst($urandom, v, -1, 1'b1);
    end

    // Reset while beat 2 is on the bus.
    rand_line(v);
    req = 1'b1;
    addr_in = 32'hCAFE_0040;
    line_in = v;
    for (int k = 0; k < NB; k++) exp_q.push_back('{a: 32'hCAFE_0040, d: v[64*k +: 64]});
    @(posedge clk); #1;
    exp_send = 1'b1;
    req = 1'b0;
    mem_resp = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    mem_resp = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    exp_send = 1'b0;
    exp_q.delete();
    #1;
    check("reset mid-burst", {busy, done, err, mem_write, mem_address, mem_wdata}, '0);
    @(posedge clk); #1;
    check("reset held", {busy, done, err, mem_write, mem_address, mem_wdata}, '0);
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

`ifdef CACHELINE_TX_TIMEOUT_EN
    // Beat 1 never answered: abort after TMO stalled cycles, no done.
    rand_line(v);
    req = 1'b1;
    addr_in = 32'h0000_2000;
    line_in = v;
    for (int k = 0; k < NB; k++) exp_q.push_back('{a: 32'h0000_2000, d: v[64*k +: 64]});
    @(posedge clk); #1;
    exp_send = 1'b1;
    req = 1'b0;
    mem_resp = 1'b1;
    @(posedge clk); #1;
    mem_resp = 1'b0;
    repeat (TMO - 1) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    exp_send = 1'b0;
    exp_err = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    exp_err = 1'b0;
`endif

    for (int n = 0; n < 4; n++) begin
      rand_line(v);
      burst($urandom, v, -1, 1'b1);
    end
    repeat (3) begin @(posedge clk); #1; end
    check("beats left", 128'(exp_q.size()), '0);
    check("dones left", 128'(done_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cacheline_burst_tx.md
# cacheline_burst_tx

Writeback serializer between the L2 data array and physical memory. It takes one full cache line read out of a data array, latches it, and transmits it as a fixed sequence of 64-bit beats on the burst memory write interface. It pulses `done` to the cache controller when the last beat is accepted. It is the transmit counterpart of the line-fill path that writes memory beats into the array.

## Interface
- `width`, default 256: cache line width in bits; must be a multiple of 64.
- `BEATS`, default `width/64`: derived beat count; not for override.
- `TIMEOUT`, default 255: per-beat response timeout in cycles; used only with `CACHELINE_TX_TIMEOUT_EN`.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  1: start a writeback; sampled only in IDLE.
- `addr_in`  in  32: line address; bits [4:0] are ignored.
- `line_in`  in  width: line data, beat 0 = bits [63:0].
- `busy`  out  1: high in SEND and DONE.
- `done`  out  1: one-cycle pulse after the last beat is accepted.
- `err`  out  1: one-cycle pulse on a timeout abort; tied 0 without the macro.
- `mem_write`  out  1: beat valid toward memory.
- `mem_address`  out  32: `{addr_q[31:5], 5'b0}`, held for the whole burst.
- `mem_wdata`  out  64: current beat.
- `mem_resp`  in  1: memory accepted the current beat.

## Operation
The FSM has three states: IDLE, SEND and DONE.

- **IDLE**
  - `mem_write`=0.
  - When `req`=1, latch `addr_in` and `line_in` into `addr_q`/`line_q`, clear `beat` to 0, and go to SEND.
- **SEND**
  - `mem_write`=1 and `mem_wdata`=`line_q[64*beat +: 64]`.
  - On `mem_resp`=1 with `beat`<BEATS-1: increment `beat` and stay in SEND.
  - On `mem_resp`=1 with `beat`=BEATS-1: go to DONE.
  - When `mem_resp`=0, hold all outputs.
- **DONE**
  - `done`=1 and `mem_write`=0.
  - Unconditionally return to IDLE.

Rules:
- `beat` is a $clog2(BEATS)-bit counter. It never wraps: the exit to DONE is taken at BEATS-1.
- `line_in` and `addr_in` may change freely after the capture cycle; the block is insensitive to them outside IDLE.
- `req` asserted outside IDLE is ignored. It is not queued.
- `mem_resp` outside SEND is ignored.
- A `mem_resp` pulse held high for multiple cycles advances one beat per cycle. Memory must deassert `mem_resp` between beats if that is not intended.

## Timing
- Reset (asynchronous, any state): state=IDLE, `beat`=0, `line_q`=0, `addr_q`=0. All outputs are 0, including `mem_address` and `mem_wdata`.
- Reset mid-burst aborts the burst at once. No `done` or `err` pulse is produced.
- `req` at edge N puts `mem_write`=1 with beat 0 in cycle N+1. All outputs are registered or decoded from registered state only.
- Minimum burst latency, with `mem_resp` high in every SEND cycle, is BEATS+1 cycles from `req` to `done`: 5 cycles for width=256.
- The earliest next `req` is accepted in the cycle after `done`, once the FSM is back in IDLE.
- `req` and `mem_resp` on the same edge in IDLE: `req` is taken and `mem_resp` is ignored.

## Configuration
Macro `CACHELINE_TX_TIMEOUT_EN`.

With the macro defined:
- An 8-bit-minimum counter, sized $clog2(TIMEOUT+1), clears on entry to SEND and on every `mem_resp`.
- The counter increments on each SEND cycle without `mem_resp`.
- When it reaches TIMEOUT, the FSM goes to IDLE with `err`=1 for one cycle and `mem_write`=0. `done` is not asserted.

Without the macro:
- No counter is present and `err`=0 constantly.
- SEND waits indefinitely for `mem_resp`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-SEND at beat 2 → next cycle all outputs are 0, state is IDLE, and no `done` pulse.
- **Back-to-back burst:** `req` with `addr_in`=0x0000_1234 and `line_in`=0x4444…_3333…_2222…_1111… (beat k = {16{hex k+1}}), `mem_resp` always 1 → `mem_address`=0x0000_1220, beats 0x1111…, 0x2222…, 0x3333…, 0x4444… in consecutive cycles, and `done` exactly 5 cycles after `req`.
- **Stalled responses:** `mem_resp` arrives 3 idle cycles after each beat → each beat is held stable for 4 cycles, `done` follows 16+1 cycles after `req`, and `mem_address` never changes.
- **Ignored request:** pulse `req` with new data during SEND, then change `line_in` → the in-flight beats are unchanged, no second burst starts, and `busy` drops after `done`.
- **Next request after done:** assert `req` in the cycle after `done` → a new burst starts, with `mem_write`=1 one cycle later.
- **Timeout (macro on, TIMEOUT=4):** no `mem_resp` after beat 1 → `err` pulses after 4 stalled cycles, `mem_write` falls, `done` never pulses, and a fresh `req` is accepted next.
